// File: rtl/cordic_vector.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vector
// Purpose  : Iterative CORDIC vectoring unit returning atan(y/x) and |v| for
//            first-quadrant inputs; one micro-rotation per clock.
// Options  : CORDIC_MAG_COMP_EN adds a SCALE step removing the CORDIC gain.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_vector #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic        [WIDTH-1:0] angle_out,
  output logic signed [WIDTH+1:0] mag_out,
  output logic                    err,
  output logic                    done
);

  localparam int                c_IW    = $clog2(WIDTH);
  localparam logic [c_IW-1:0]   c_LAST  = c_IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  c_ANG90 = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ITER  = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic signed [WIDTH+1:0] r_x;
  logic signed [WIDTH+1:0] r_y;
  logic        [WIDTH-1:0] r_z;
  logic        [c_IW-1:0]  r_iter;
  logic                    r_err;

  logic signed [WIDTH+1:0] w_xs;
  logic signed [WIDTH+1:0] w_ys;
  logic        [WIDTH-1:0] w_atan;
  logic                    w_neg;
  logic                    w_x_zero;
  logic                    w_y_zero;

  // Angle ROM in a 32-bit scale where 2^30 = 45 deg, rescaled to WIDTH bits.
  function automatic logic [WIDTH-1:0] f_atan(input logic [c_IW-1:0] idx);
    logic [31:0] v;
    case (int'(idx))
      0:       v = 32'h4000_0000;
      1:       v = 32'h25C8_0A3B;
      2:       v = 32'h13F6_70B7;
      3:       v = 32'h0A22_23A8;
      4:       v = 32'h0516_1A86;
      5:       v = 32'h028B_AFC3;
      6:       v = 32'h0145_EC3D;
      7:       v = 32'h00A2_F8AA;
      8:       v = 32'h0051_7CA7;
      9:       v = 32'h0028_BE5D;
      10:      v = 32'h0014_5F30;
      11:      v = 32'h000A_2F98;
      12:      v = 32'h0005_17CC;
      13:      v = 32'h0002_8BE6;
      14:      v = 32'h0001_45F3;
      15:      v = 32'h0000_A2FA;
      16:      v = 32'h0000_517D;
      17:      v = 32'h0000_28BE;
      18:      v = 32'h0000_145F;
      19:      v = 32'h0000_0A30;
      20:      v = 32'h0000_0518;
      21:      v = 32'h0000_028C;
      22:      v = 32'h0000_0146;
      23:      v = 32'h0000_00A3;
      24:      v = 32'h0000_0051;
      25:      v = 32'h0000_0029;
      26:      v = 32'h0000_0014;
      27:      v = 32'h0000_000A;
      28:      v = 32'h0000_0005;
      29:      v = 32'h0000_0003;
      30:      v = 32'h0000_0001;
      31:      v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return WIDTH'({v, 32'h0} >> (64 - WIDTH));
  endfunction

  always_comb begin
    w_xs     = r_x >>> r_iter;
    w_ys     = r_y >>> r_iter;
    w_atan   = f_atan(r_iter);
    w_neg    = x_in[WIDTH-1] | y_in[WIDTH-1];
    w_x_zero = (x_in == '0);
    w_y_zero = (y_in == '0);
  end

`ifdef CORDIC_MAG_COMP_EN
  // 1/K for the CORDIC gain, Q1.31; the full product keeps every bit before truncation.
  localparam logic signed [32:0] c_GAIN_INV = 33'sh0_4DBA_76D4;
  logic signed [WIDTH+34:0] w_prod;
  logic signed [WIDTH+1:0]  w_scaled;
  assign w_prod   = r_x * c_GAIN_INV;
  assign w_scaled = (WIDTH+2)'(w_prod >>> 31);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          if (w_neg || w_x_zero || w_y_zero) begin
            w_next = DONE;
          end else begin
            w_next = INIT;
          end
        end
      end
      INIT:  w_next = ITER;
      ITER: begin
        if (r_iter == c_LAST) begin
`ifdef CORDIC_MAG_COMP_EN
          w_next = SCALE;
`else
          w_next = DONE;
`endif
        end
      end
      SCALE: w_next = DONE;
      DONE: begin
        if (!valid_in) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_iter    <= '0;
      r_err     <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (valid_in) begin
            r_x    <= {{2{x_in[WIDTH-1]}}, x_in};
            r_y    <= {{2{y_in[WIDTH-1]}}, y_in};
            r_z    <= '0;
            r_iter <= '0;
            r_err  <= 1'b0;
            // Shortcut/error paths park their final result in r_x/r_z for DONE.
            if (w_neg) begin
              r_x   <= '0;
              r_y   <= '0;
              r_err <= 1'b1;
            end else if (w_y_zero) begin
              r_y <= '0;
            end else if (w_x_zero) begin
              r_x <= {{2{y_in[WIDTH-1]}}, y_in};
              r_y <= '0;
              r_z <= c_ANG90;
            end
          end
        end
        INIT: begin
          r_z    <= '0;
          r_iter <= '0;
          r_err  <= 1'b0;
        end
        ITER: begin
          if (!r_y[WIDTH+1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_iter <= r_iter + c_IW'(1);
        end
`ifdef CORDIC_MAG_COMP_EN
        SCALE: r_x <= w_scaled;
`endif
        DONE: begin
          done      <= 1'b1;
          angle_out <= r_z;
          mag_out   <= r_x;
          err       <= r_err;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_vector
// Purpose  : Directed self-checking bench for cordic_vector; expectations
//            follow CORDIC_MAG_COMP_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cordic_vector;

  localparam int WIDTH = 32;
`ifdef CORDIC_MAG_COMP_EN
  localparam int     LAT_ITER = WIDTH + 3;
  localparam longint MAG45    = 64'sd759250124;
  localparam longint TOL45    = 16;
  localparam longint MAG30    = 64'sd2479700525;
  localparam longint TOL30    = 32;
`else
  localparam int     LAT_ITER = WIDTH + 2;
  localparam longint MAG45    = 64'sd1250302932;
  localparam longint TOL45    = 64;
  localparam longint MAG30    = 64'sd4083472276;
  localparam longint TOL30    = 64;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic        [WIDTH-1:0] angle_out;
  logic signed [WIDTH+1:0] mag_out;
  logic                    err;
  logic                    done;

  int n_pass  = 0;
  int n_total = 0;

  cordic_vector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .err       (err),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Drive a request; returns just after the sampling edge E0.
  task automatic start_req(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    x_in     = x;
    y_in     = y;
    valid_in = 1'b1;
    @(posedge clk);
  endtask

  // Edges after E0 until done; scrambles inputs after E1 and optionally drops valid_in.
  task automatic wait_done(input int drop_from, input int drop_to, output int lat);
    lat = -1;
    #1;
    for (int n = 1; n <= 200; n++) begin
      if (n == 2) begin
        x_in = x_in ^ 32'h1234_5678;
        y_in = ~y_in;
      end
      if (n == drop_from) valid_in = 1'b0;
      if (n == drop_to)   valid_in = 1'b1;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (done !== 1'b0)       $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (err !== 1'b0)        $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_total++; if (angle_out !== 32'h0) $display("FAIL reset_angle: got %h want 0", angle_out); else n_pass++;
    n_total++; if (mag_out !== 34'h0)   $display("FAIL reset_mag: got %h want 0", mag_out); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_shortcut_x();
    int lat;
    start_req(32'h4000_0000, 32'h0);
    wait_done(0, 0, lat);
    n_total++; if (lat !== 1)                 $display("FAIL sx_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (angle_out !== 32'h0)       $display("FAIL sx_angle: got %h want 0", angle_out); else n_pass++;
    n_total++; if (mag_out !== 34'h4000_0000) $display("FAIL sx_mag: got %h want 040000000", mag_out); else n_pass++;
    n_total++; if (err !== 1'b0)              $display("FAIL sx_err: got %b want 0", err); else n_pass++;
    release_req();
  endtask

  task automatic test_shortcut_y();
    int lat;
    start_req(32'h0, 32'h1000_0000);
    wait_done(0, 0, lat);
    n_total++; if (lat !== 1)                 $display("FAIL sy_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (angle_out !== 32'h8000_0000) $display("FAIL sy_angle: got %h want 80000000", angle_out); else n_pass++;
    n_total++; if (mag_out !== 34'h1000_0000) $display("FAIL sy_mag: got %h want 010000000", mag_out); else n_pass++;
    n_total++; if (err !== 1'b0)              $display("FAIL sy_err: got %b want 0", err); else n_pass++;
    release_req();
  endtask

  task automatic test_zero();
    int lat;
    start_req(32'h0, 32'h0);
    wait_done(0, 0, lat);
    n_total++; if (lat !== 1)           $display("FAIL zero_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (angle_out !== 32'h0) $display("FAIL zero_angle: got %h want 0", angle_out); else n_pass++;
    n_total++; if (mag_out !== 34'h0)   $display("FAIL zero_mag: got %h want 0", mag_out); else n_pass++;
    release_req();
  endtask

  task automatic test_error();
    int lat;
    start_req(32'hF000_0000, 32'h1);
    wait_done(0, 0, lat);
    n_total++; if (lat !== 1)           $display("FAIL err_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (err !== 1'b1)        $display("FAIL err_flag: got %b want 1", err); else n_pass++;
    n_total++; if (angle_out !== 32'h0) $display("FAIL err_angle: got %h want 0", angle_out); else n_pass++;
    n_total++; if (mag_out !== 34'h0)   $display("FAIL err_mag: got %h want 0", mag_out); else n_pass++;
    release_req();
  endtask

  task automatic test_iter_45();
    int     lat;
    longint d;
    start_req(32'h2000_0000, 32'h2000_0000);
    wait_done(0, 0, lat);
    n_total++; if (lat !== LAT_ITER) $display("FAIL i45_latency: got %0d want %0d", lat, LAT_ITER); else n_pass++;
    d = longint'(angle_out) - 64'sh4000_0000;
    n_total++; if (d < -64 || d > 64) $display("FAIL i45_angle: got %h want 40000000 +/-64", angle_out); else n_pass++;
    d = longint'(mag_out) - MAG45;
    n_total++; if (d < -TOL45 || d > TOL45) $display("FAIL i45_mag: got %0d want %0d +/-%0d", mag_out, MAG45, TOL45); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL i45_err: got %b want 0", err); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (done !== 1'b1) $display("FAIL i45_hold_done: got %b want 1", done); else n_pass++;
    d = longint'(angle_out) - 64'sh4000_0000;
    n_total++; if (d < -64 || d > 64) $display("FAIL i45_hold_angle: got %h want 40000000 +/-64", angle_out); else n_pass++;
    release_req();
    n_total++; if (done !== 1'b1) $display("FAIL i45_done_lag: got %b want 1", done); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (done !== 1'b0) $display("FAIL i45_done_fall: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_iter_30();
    int     lat;
    longint d;
    start_req(32'h7FFF_FFFF, 32'h49E6_9D16);
    wait_done(5, 9, lat);
    n_total++; if (lat !== LAT_ITER) $display("FAIL i30_latency: got %0d want %0d", lat, LAT_ITER); else n_pass++;
    d = longint'(angle_out) - 64'sh2AAA_AAAB;
    n_total++; if (d < -64 || d > 64) $display("FAIL i30_angle: got %h want 2AAAAAAB +/-64", angle_out); else n_pass++;
    d = longint'(mag_out) - MAG30;
    n_total++; if (d < -TOL30 || d > TOL30) $display("FAIL i30_mag: got %0d want %0d +/-%0d", mag_out, MAG30, TOL30); else n_pass++;
    release_req();
  endtask

  task automatic test_reset_mid_iter();
    int     lat;
    longint d;
    start_req(32'h2000_0000, 32'h2000_0000);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (done !== 1'b0)       $display("FAIL rmid_done: got %b want 0", done); else n_pass++;
    n_total++; if (angle_out !== 32'h0) $display("FAIL rmid_angle: got %h want 0", angle_out); else n_pass++;
    n_total++; if (mag_out !== 34'h0)   $display("FAIL rmid_mag: got %h want 0", mag_out); else n_pass++;
    n_total++; if (err !== 1'b0)        $display("FAIL rmid_err: got %b want 0", err); else n_pass++;
    @(negedge clk);
    rst      = 1'b1;
    x_in     = 32'h2000_0000;
    y_in     = 32'h2000_0000;
    valid_in = 1'b1;
    @(posedge clk);
    wait_done(0, 0, lat);
    n_total++; if (lat !== LAT_ITER) $display("FAIL rmid_latency: got %0d want %0d", lat, LAT_ITER); else n_pass++;
    d = longint'(angle_out) - 64'sh4000_0000;
    n_total++; if (d < -64 || d > 64) $display("FAIL rmid_new_angle: got %h want 40000000 +/-64", angle_out); else n_pass++;
    d = longint'(mag_out) - MAG45;
    n_total++; if (d < -TOL45 || d > TOL45) $display("FAIL rmid_new_mag: got %0d want %0d +/-%0d", mag_out, MAG45, TOL45); else n_pass++;
    release_req();
  endtask

  initial begin
    test_reset();
    test_shortcut_x();
    test_shortcut_y();
    test_zero();
    test_error();
    test_iter_45();
    test_iter_30();
    test_reset_mid_iter();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
